// File: rtl/multi_port_regfile_pkg.sv
// regfile_pkg: shared defaults and sizing/slicing helpers for the multi-port register file.
package regfile_pkg;
    localparam int XLEN_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NREAD_DEF = 2;

    function automatic int addr_width(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

    // Low bit of port `port` inside a packed bus of `width`-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction
endpackage

// File: rtl/multi_port_regfile_if.sv
// multi_port_regfile_if: read, writeback and reservation signals of the register file.
interface multi_port_regfile_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NREAD = NREAD_DEF,
    parameter int AW = addr_width(DEPTH)
);
    logic [NREAD-1:0] readEn;
    logic [NREAD*AW-1:0] readAddr;
    logic [NREAD*XLEN-1:0] readData;
    logic [NREAD-1:0] readBusy;
    logic wrEn0;
    logic wrEn1;
    logic [AW-1:0] wrAddr0;
    logic [AW-1:0] wrAddr1;
    logic [XLEN-1:0] wrData0;
    logic [XLEN-1:0] wrData1;
    logic reserveEn;
    logic [AW-1:0] reserveAddr;
    logic flush;

    modport master (
        output readEn, readAddr, wrEn0, wrEn1, wrAddr0, wrAddr1, wrData0, wrData1,
               reserveEn, reserveAddr, flush,
        input  readData, readBusy
    );

    modport slave (
        input  readEn, readAddr, wrEn0, wrEn1, wrAddr0, wrAddr1, wrData0, wrData1,
               reserveEn, reserveAddr, flush,
        output readData, readBusy
    );
endinterface

// File: rtl/multi_port_regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register for issue-stage hazard checks.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int NREAD = NREAD_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en0,
    input  logic [AW-1:0] wr_addr0,
    input  logic wr_en1,
    input  logic [AW-1:0] wr_addr1,
    input  logic reserve_en,
    input  logic [AW-1:0] reserve_addr,
    input  logic flush,
    input  logic [NREAD*AW-1:0] read_addr,
    output logic [NREAD-1:0] read_busy
);
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] nxt;
    logic res;

    assign res = reserve_en && !(ZERO_REG != 0 && reserve_addr == '0);

    // Later assignments win: reservation beats retire clear, flush beats everything.
    always_comb begin
        nxt = busy;
        if (wr_en0) nxt[wr_addr0] = 1'b0;
        if (wr_en1) nxt[wr_addr1] = 1'b0;
        if (res) nxt[reserve_addr] = 1'b1;
        if (flush) nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else busy <= nxt;
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_busy
        logic [AW-1:0] ra;
        assign ra = read_addr[slice_lo(g, AW) +: AW];
        assign read_busy[g] = busy[ra] && !(ZERO_REG != 0 && ra == '0);
    end
endmodule

// File: rtl/multi_port_regfile.sv
// multi_port_regfile: two-write, NREAD-read register file with write-first bypass
// into registered read ports and an integrated busy-bit scoreboard.
module multi_port_regfile
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NREAD = NREAD_DEF,
    parameter int ZERO_REG = 1
) (
    input logic clk,
    input logic rst_n,
    multi_port_regfile_if.slave bus
);
    localparam int AW = addr_width(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic w0;
    logic w1;

    assign w0 = bus.wrEn0 && !(ZERO_REG != 0 && bus.wrAddr0 == '0);
    assign w1 = bus.wrEn1 && !(ZERO_REG != 0 && bus.wrAddr1 == '0);

    // Lane 1 is written last so it wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (w0) mem[bus.wrAddr0] <= bus.wrData0;
            if (w1) mem[bus.wrAddr1] <= bus.wrData1;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic [XLEN-1:0] nxt;
        logic [XLEN-1:0] q;
        assign ra = bus.readAddr[slice_lo(g, AW) +: AW];
        always_comb
            nxt = (ZERO_REG != 0 && ra == '0) ? '0 :
                  (w1 && bus.wrAddr1 == ra) ? bus.wrData1 :
                  (w0 && bus.wrAddr0 == ra) ? bus.wrData0 : mem[ra];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else if (bus.readEn[g]) q <= nxt;
        end
        assign bus.readData[slice_lo(g, XLEN) +: XLEN] = q;
    end

    regfile_scoreboard #(
        .DEPTH(DEPTH),
        .NREAD(NREAD),
        .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en0(bus.wrEn0),
        .wr_addr0(bus.wrAddr0),
        .wr_en1(bus.wrEn1),
        .wr_addr1(bus.wrAddr1),
        .reserve_en(bus.reserveEn),
        .reserve_addr(bus.reserveAddr),
        .flush(bus.flush),
        .read_addr(bus.readAddr),
        .read_busy(bus.readBusy)
    );
endmodule
